// File: rtl/mem_burst_master.sv
// mem_burst_master
// Bus initiator for a single-port word memory with an addr_en/in_en/out_en strobe
// interface. A host burst request (base, length, direction) is turned into
// per-word sequences: latch the address, then write or read one word.
// Write data arrives on a valid/ready stream. Read data leaves as a one-cycle
// valid pulse per word and is not backpressured.
//
// Optional feature: define WRITE_VERIFY_EN to add a read-back (VRFY) cycle after
// every written word. A mismatch sets a sticky err flag, which the next accepted
// burst clears. When the macro is undefined there is no VRFY state and err is
// tied to 0.

module mem_burst_master #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    output logic              ready,
    input  logic              we,
    input  logic [ADDR_W-1:0] base,
    input  logic [LEN_W-1:0]  len_m1,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              err,
    output logic              mem_addr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_in_en,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_out_en,
    input  logic [DATA_W-1:0] mem_out
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_XFER = 3'd2,
        S_VRFY = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    state_t            r_state;
    logic              r_we;
    logic [ADDR_W-1:0] r_cur;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_addr_en;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_out_en;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_done;
`ifdef WRITE_VERIFY_EN
    logic              r_err;
    logic [DATA_W-1:0] r_wr_word;
`endif

    logic              w_wr_fire;
    logic              w_last;
    logic [ADDR_W-1:0] w_cur_inc;
    logic [LEN_W-1:0]  w_cnt_dec;

    // Write handshake and next-word arithmetic; the write strobe must coincide with wr_valid
    always_comb begin
        w_wr_fire = 1'b0;
        if ((r_state == S_XFER) && r_we && wr_valid) begin
            w_wr_fire = 1'b1;
        end else begin
            w_wr_fire = 1'b0;
        end
        w_last    = (r_cnt == LEN_ZERO);
        w_cur_inc = r_cur + ADDR_ONE;
        w_cnt_dec = r_cnt - LEN_ONE;
    end

    // Output mapping: ready decodes the state, write-side strobes follow the handshake
    always_comb begin
        ready       = (r_state == S_IDLE);
        wr_ready    = w_wr_fire;
        mem_in_en   = w_wr_fire;
        mem_in      = wr_data;
        mem_addr_en = r_addr_en;
        mem_addr    = r_mem_addr;
        mem_out_en  = r_out_en;
        rd_data     = r_rd_data;
        rd_valid    = r_rd_valid;
        done        = r_done;
`ifdef WRITE_VERIFY_EN
        err         = r_err;
`else
        err         = 1'b0;
`endif
    end

    // Burst FSM: sequences the address, transfer and verify phases and registers the strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_cur      <= ADDR_ZERO;
            r_cnt      <= LEN_ZERO;
            r_addr_en  <= 1'b0;
            r_mem_addr <= ADDR_ZERO;
            r_out_en   <= 1'b0;
            r_rd_data  <= DATA_ZERO;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
`ifdef WRITE_VERIFY_EN
            r_err      <= 1'b0;
            r_wr_word  <= DATA_ZERO;
`endif
        end else begin
            // Strobes and pulses are single-cycle unless a branch below re-asserts them
            r_addr_en  <= 1'b0;
            r_out_en   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_we       <= we;
                        r_cur      <= base;
                        r_cnt      <= len_m1;
                        r_mem_addr <= base;
                        r_addr_en  <= 1'b1;
`ifdef WRITE_VERIFY_EN
                        r_err      <= 1'b0;
`endif
                        r_state    <= S_ADDR;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ADDR: begin
                    // A read strobes out_en for the whole XFER cycle. A write waits for wr_valid.
                    r_out_en <= ~r_we;
                    r_state  <= S_XFER;
                end
                S_XFER: begin
                    if (r_we) begin
                        if (wr_valid) begin
`ifdef WRITE_VERIFY_EN
                            r_wr_word <= wr_data;
                            r_out_en  <= 1'b1;
                            r_state   <= S_VRFY;
`else
                            if (w_last) begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_cnt      <= w_cnt_dec;
                                r_cur      <= w_cur_inc;
                                r_mem_addr <= w_cur_inc;
                                r_addr_en  <= 1'b1;
                                r_state    <= S_ADDR;
                            end
`endif
                        end else begin
                            // Stall: no strobes, and the latched memory address stays put
                            r_state <= S_XFER;
                        end
                    end else begin
                        r_rd_data  <= mem_out;
                        r_rd_valid <= 1'b1;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt      <= w_cnt_dec;
                            r_cur      <= w_cur_inc;
                            r_mem_addr <= w_cur_inc;
                            r_addr_en  <= 1'b1;
                            r_state    <= S_ADDR;
                        end
                    end
                end
`ifdef WRITE_VERIFY_EN
                S_VRFY: begin
                    if (mem_out != r_wr_word) begin
                        r_err <= 1'b1;
                    end else begin
                        r_err <= r_err;
                    end
                    if (w_last) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt      <= w_cnt_dec;
                        r_cur      <= w_cur_inc;
                        r_mem_addr <= w_cur_inc;
                        r_addr_en  <= 1'b1;
                        r_state    <= S_ADDR;
                    end
                end
`endif
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_master.sv
// Scoreboard bench for mem_burst_master.
// Includes a word-memory model. The verify corruption at 0x0020 is active only
// when WRITE_VERIFY_EN is defined.

module tb_mem_burst_master;

    logic        clk;
    logic        rst;
    logic        req;
    logic        ready;
    logic        we;
    logic [15:0] base;
    logic [7:0]  len_m1;
    logic [15:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        done;
    logic        err;
    logic        mem_addr_en;
    logic [15:0] mem_addr;
    logic        mem_in_en;
    logic [15:0] mem_in;
    logic        mem_out_en;
    logic [15:0] mem_out;

    mem_burst_master #(.ADDR_W(16), .DATA_W(16), .LEN_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .ready(ready), .we(we), .base(base),
        .len_m1(len_m1), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
        .mem_addr_en(mem_addr_en), .mem_addr(mem_addr), .mem_in_en(mem_in_en),
        .mem_in(mem_in), .mem_out_en(mem_out_en), .mem_out(mem_out)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard queues and write-data source
    wr_t         exp_wr[$];
    logic [15:0] exp_rd[$];
    logic [15:0] wr_q[$];
    int          stall_pending = 0;
    int          stall_cnt = 0;
    logic        take = 1'b0;

    // Monitor counters
    int edge_cnt = 0;
    int done_cnt = 0;
    int cnt_addr = 0;
    int cnt_in = 0;
    int cnt_out = 0;
    int cnt_wrr = 0;
    int rd_first_edge = -1;
    int acc_edge = 0;

    // Memory model
    logic [15:0] mem [0:65535];
    logic [15:0] lat_addr = 16'h0000;
    assign mem_out = mem[lat_addr];

    // Memory: latch the address on addr_en and write to the previously latched address on in_en
    always @(posedge clk) begin
        if (mem_addr_en) lat_addr <= mem_addr;
        if (mem_in_en) begin
`ifdef WRITE_VERIFY_EN
            if (lat_addr == 16'h0020) mem[lat_addr] <= mem_in ^ 16'h00FF;
            else mem[lat_addr] <= mem_in;
`else
            mem[lat_addr] <= mem_in;
`endif
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    end

    initial forever begin
        @(posedge clk);
        edge_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s act=missing exp=present", name);
    endtask

    // Write data driver: presents the head of wr_q and inserts stalls after a consumed word
    initial begin
        wr_valid = 1'b0;
        wr_data  = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            if (take) begin
                void'(wr_q.pop_front());
                take = 1'b0;
                if (stall_pending > 0) begin
                    stall_cnt = stall_pending;
                    stall_pending = 0;
                end
            end
            if (stall_cnt > 0) begin
                wr_valid = 1'b0;
                stall_cnt--;
            end else if (wr_q.size() > 0) begin
                wr_valid = 1'b1;
                wr_data  = wr_q[0];
            end else begin
                wr_valid = 1'b0;
            end
        end
    end

    // Monitor: samples on the falling edge and pops the scoreboard whenever the DUT presents data
    initial forever begin
        wr_t e;
        logic [15:0] r;
        @(negedge clk);
        if (rst) begin
            if (wr_valid && wr_ready) take = 1'b1;
            if (wr_ready) cnt_wrr++;
            if (mem_out_en) cnt_out++;
            if (mem_addr_en) begin
                cnt_addr++;
                check("strobe_excl", {30'd0, mem_in_en, mem_out_en}, 32'd0);
            end
            if (mem_in_en) begin
                cnt_in++;
                if (exp_wr.size() == 0) fail("wr_unexpected");
                else begin
                    e = exp_wr.pop_front();
                    check("wr_addr", {16'd0, lat_addr}, {16'd0, e.a});
                    check("wr_data", {16'd0, mem_in}, {16'd0, e.d});
                end
            end
            if (rd_valid) begin
                if (rd_first_edge < 0) rd_first_edge = edge_cnt + 1;
                if (exp_rd.size() == 0) fail("rd_unexpected");
                else begin
                    r = exp_rd.pop_front();
                    check("rd_data", {16'd0, rd_data}, {16'd0, r});
                end
            end
            if (done) begin
                done_cnt++;
                check("ready_in_done", {31'd0, ready}, 32'd0);
            end
        end
    end

    task automatic do_burst(input logic w, input logic [15:0] b, input logic [7:0] l);
        int k;
        @(posedge clk);
        #1;
        for (k = 0; k < 100 && !ready; k++) begin
            @(posedge clk);
            #1;
        end
        if (!ready) fail("ready_timeout");
        req = 1'b1; we = w; base = b; len_m1 = l;
        @(posedge clk);
        #1;
        req = 1'b0;
        acc_edge = edge_cnt;
    endtask

    task automatic wait_done(input int target);
        int k;
        for (k = 0; k < 300 && done_cnt < target; k++) begin
            @(posedge clk);
            #1;
        end
        if (done_cnt < target) fail("done_timeout");
        else check("ready_after_done", {31'd0, ready}, 32'd1);
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_wr.push_back(e);
        wr_q.push_back(d);
    endtask

    int s_wrr, s_addr, s_in, s_out;

    initial begin
        rst = 1'b0; req = 1'b0; we = 1'b0; base = 16'h0000; len_m1 = 8'h00;
        #1;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_strobes", {29'd0, mem_addr_en, mem_in_en, mem_out_en}, 32'd0);
        check("rst_rd_data", {16'd0, rd_data}, 32'd0);
        #20 rst = 1'b1;

        // Write burst 0x0010..0x0012
        push_wr(16'h0010, 16'hA001);
        push_wr(16'h0011, 16'hA002);
        push_wr(16'h0012, 16'hA003);
        s_wrr = cnt_wrr;
        do_burst(1'b1, 16'h0010, 8'd2);
        wait_done(1);
        check("wr_ready_pulses", cnt_wrr - s_wrr, 32'd3);
        check("mem10", {16'd0, mem[16'h0010]}, 32'hA001);
        check("mem11", {16'd0, mem[16'h0011]}, 32'hA002);
        check("mem12", {16'd0, mem[16'h0012]}, 32'hA003);

        // Read the same range back and check first-word latency
        exp_rd.push_back(16'hA001);
        exp_rd.push_back(16'hA002);
        exp_rd.push_back(16'hA003);
        rd_first_edge = -1;
        do_burst(1'b0, 16'h0010, 8'd2);
        wait_done(2);
        check("rd_latency", rd_first_edge - acc_edge, 32'd3);
        check("rd_all_seen", exp_rd.size(), 32'd0);
        check("done_once", done_cnt, 32'd2);

        // Address wrap with a 4-cycle wr_valid stall before word 1
        push_wr(16'hFFFF, 16'hC001);
        push_wr(16'h0000, 16'hC002);
        stall_pending = 4;
        s_addr = cnt_addr; s_in = cnt_in; s_out = cnt_out;
        do_burst(1'b1, 16'hFFFF, 8'd1);
        wait_done(3);
        check("memFFFF", {16'd0, mem[16'hFFFF]}, 32'hC001);
        check("mem0000", {16'd0, mem[16'h0000]}, 32'hC002);
        check("wrap_addr_en", cnt_addr - s_addr, 32'd2);
        check("wrap_in_en", cnt_in - s_in, 32'd2);
`ifdef WRITE_VERIFY_EN
        check("wrap_out_en", cnt_out - s_out, 32'd2);
`else
        check("wrap_out_en", cnt_out - s_out, 32'd0);
`endif

        // Busy: a second request during the burst must be ignored
        push_wr(16'h0040, 16'hB001);
        push_wr(16'h0041, 16'hB002);
        push_wr(16'h0042, 16'hB003);
        push_wr(16'h0043, 16'hB004);
        do_burst(1'b1, 16'h0040, 8'd3);
        repeat (2) begin @(posedge clk); #1; end
        req = 1'b1; we = 1'b0; base = 16'h0080; len_m1 = 8'd0;
        for (int i = 0; i < 3; i++) begin
            check("busy_ready", {31'd0, ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        req = 1'b0;
        wait_done(4);
        repeat (4) begin @(posedge clk); #1; end
        check("busy_done_cnt", done_cnt, 32'd4);
        check("busy_idle", {31'd0, ready}, 32'd1);
        check("mem43", {16'd0, mem[16'h0043]}, 32'hB004);
        check("busy_no_rd", exp_rd.size(), 32'd0);

        // Write verify: the memory model corrupts the word at 0x0020
        push_wr(16'h001F, 16'hD001);
        push_wr(16'h0020, 16'hD002);
        push_wr(16'h0021, 16'hD003);
        do_burst(1'b1, 16'h001F, 8'd2);
        wait_done(5);
`ifdef WRITE_VERIFY_EN
        check("verify_err", {31'd0, err}, 32'd1);
`else
        check("verify_err", {31'd0, err}, 32'd0);
`endif
        check("mem21", {16'd0, mem[16'h0021]}, 32'hD003);
        exp_rd.push_back(16'hA001);
        do_burst(1'b0, 16'h0010, 8'd0);
        check("err_cleared", {31'd0, err}, 32'd0);
        wait_done(6);

        // Reset in the middle of a long read burst
        exp_rd.push_back(16'hA001);
        exp_rd.push_back(16'hA002);
        exp_rd.push_back(16'hA003);
        do_burst(1'b0, 16'h0010, 8'd7);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_ready", {31'd0, ready}, 32'd1);
        check("mid_rst_pulses", {30'd0, rd_valid, done}, 32'd0);
        check("mid_rst_strobes", {29'd0, mem_addr_en, mem_in_en, mem_out_en}, 32'd0);
        check("mid_rst_rd_data", {16'd0, rd_data}, 32'd0);
        exp_rd.delete();
        #10 rst = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        check("mid_rst_no_done", done_cnt, 32'd6);
        check("no_stray_writes", exp_wr.size(), 32'd0);

        // Recovery after reset
        exp_rd.push_back(16'hA002);
        do_burst(1'b0, 16'h0011, 8'd0);
        wait_done(7);
        check("recover_rd", exp_rd.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
